tetris_renderer: RTL and testbench
==================================

TETRIS_RENDERER -- requirements
Module: tetris_renderer

Interface
REQ-001 Parameters (name, default, meaning):
- COLS 10: board columns
- ROWS 20: board rows
- CELL_PX 20: on-screen cell size in pixels
- SCALE_SHIFT 1: log2 of image upscale
- BOARD_X0 220, BOARD_Y0 40: board top-left pixel
- KINDS 7: tile kinds, numbered 1..KINDS
- DIGITS 4: score digits
- DIGIT_X0 128, DIGIT_Y0 450, DIGIT_PITCH 14: digit 0 (most significant) origin and step, in pixels
- NUM_W 5, NUM_H 9: unscaled digit image size
- BG_W 320: unscaled background width
- ROM_AW 17: tile ROM address width
- FLASH_FRAMES 24: total flash length in frames
- FLASH_HALF 4: frames per flash on/off phase
- FLASH_COLOR 12'hFF0: colour of flashed rows
- KEY_COLOR 12'hFFF: transparent tile colour
REQ-002 Ports (name, direction, width, meaning):
- clk in 1: system clock
- reset in 1: synchronous, active-high reset
- pixel_x, pixel_y in 10: raster position from the sync generator
- visible in 1: pixel is in the active area
- p_tick in 1: pixel strobe
- hsync_in, vsync_in in 1: raw sync signals
- cell_x out clog2(COLS), cell_y out clog2(ROWS): board cell query
- cell_kind in 4: combinational board answer for the cell on cell_x/cell_y, 0 = empty
- score in 4*DIGITS: BCD score, digit 0 in the top nibble
- game_over in 1: level, dims the board
- clear_start in 1: one-cycle request to flash rows
- clear_rows in ROWS: row mask, bit r = board row r
- busy out 1: flash in progress
- clear_done out 1: one-cycle pulse when a flash ends
- tile_addr out ROM_AW, tile_data in 12: tile/digit ROM port, 1-cycle read latency
- bg_addr out 17, bg_data in 12: background ROM port, 1-cycle read latency
- vga_hsync, vga_vsync out 1, vga_rgb out 12: display outputs

Function
REQ-003 in_board SHALL be BOARD_X0<=pixel_x<BOARD_X0+COLS*CELL_PX and BOARD_Y0<=pixel_y<BOARD_Y0+ROWS*CELL_PX.
REQ-004 cell_x/cell_y SHALL be combinational: (pixel-origin)/CELL_PX when in_board, else 0.
REQ-005 Offsets within a cell SHALL be (pixel-origin)%CELL_PX>>SCALE_SHIFT; TILE=CELL_PX>>SCALE_SHIFT.
REQ-006 Tile ROM layout: kind k (1..KINDS) at (k-1)*TILE*TILE; digit d at KINDS*TILE*TILE+d*NUM_W*NUM_H; one KEY_COLOR word at KEY_ADDR=KINDS*TILE*TILE+10*NUM_W*NUM_H.
REQ-007 Stage 1 (registered every clk): tile_addr SHALL be the following, first match wins:
- board pixel with cell_kind in 1..KINDS: kind base + row*TILE+col
- board pixel with kind 0 or >KINDS: KEY_ADDR
- digit box i (DIGIT_X0+i*DIGIT_PITCH, DIGIT_Y0, size NUM_W<<SCALE_SHIFT by NUM_H<<SCALE_SHIFT), digit shown: that digit's pixel
- otherwise: KEY_ADDR
REQ-008 Digit i SHALL be blanked (KEY_ADDR) when its nibble >9, or when i<DIGITS-1 and it and all more-significant nibbles are 0; the least significant digit always shows, 0 included.
REQ-009 bg_addr SHALL register (pixel_y>>SCALE_SHIFT)*BG_W+(pixel_x>>SCALE_SHIFT) every clk.
REQ-010 Stage 1 SHALL also register visible, p_tick, hsync_in, vsync_in, in_board, and the flash-hit flag: flash active, flash phase on, in_board, clear_rows_latched[cell_y]=1.
REQ-011 Stage 2 SHALL delay those flags one more clk to line up with ROM data.
REQ-012 Stage 3 composition, priority order:
- !visible: 0
- flash-hit: FLASH_COLOR
- tile_data!=KEY_COLOR: tile_data
- otherwise: bg_data
- then, if game_over and board pixel, each 4-bit channel >>1
REQ-013 vga_rgb SHALL load the stage-3 result only in cycles where delayed p_tick=1, and hold otherwise.
REQ-014 vga_hsync/vga_vsync SHALL load every clk from the stage-2 syncs; total latency from pixel inputs to outputs is 3 clks.
REQ-015 frame_tick SHALL be p_tick & pixel_x==0 & pixel_y==0.
REQ-016 Flash FSM:
- IDLE + clear_start: latch clear_rows, frame count fc=0, go to FLASH
- FLASH: fc+1 per frame_tick
- phase on when (fc/FLASH_HALF) is even
- fc==FLASH_FRAMES-1 with frame_tick: clear_done=1 for that clk, go to IDLE
REQ-017 busy SHALL be 1 exactly in FLASH.
REQ-018 clear_start in FLASH SHALL be ignored, mask not re-latched; clear_start with an all-zero mask still runs a full flash.
REQ-019 clear_start coincident with frame_tick in IDLE SHALL enter FLASH with fc=0; that tick is not counted.

Reset
REQ-020 reset SHALL force:
- FSM to IDLE, fc=0, mask=0
- busy=0, clear_done=0
- tile_addr=KEY_ADDR, bg_addr=0
- all pipeline flags 0
- vga_rgb=0, vga_hsync=0, vga_vsync=0
REQ-021 reset during FLASH SHALL abort the flash with no clear_done pulse.

Verification
REQ-022 Pixel (220,40), cell_kind=3, default parameters:
- cell_x=0, cell_y=0
- next clk tile_addr=200
REQ-023 Pixel (239,59):
- offsets (9,9)
- tile_addr=base+99
REQ-024 score=16'h0042:
- digits 0 and 1 blanked, digits 2 and 3 show 4 and 2
- score=0: only digit 3 shows 0
REQ-025 clear_start with clear_rows bit 5 set:
- row 5 pixels = 12'hFF0 in frames 0-3, 8-11, 16-19
- normal colour in the other frames
- clear_done pulses after frame 23, busy falls with it
REQ-026 game_over=1, tile_data=12'hF84 on a board pixel -> vga_rgb=12'h742; background pixel outside the board is unaffected.
REQ-027 Pulse p_tick with visible=1:
- vga_rgb changes exactly 3 clks after the p_tick
- reset asserted mid-flash -> busy=0 next clk, no clear_done pulse

Source files
------------

// File: rtl/tetris_renderer.sv
// tetris_renderer
// Three-stage pixel pipeline that draws a Tetris board, a BCD score and a
// background image, plus a small FSM that flashes cleared rows for a fixed
// number of frames.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no flash; waiting for clear_start
// S_FLASH | latched rows blink; r_fc counts frames (one per frame_tick)
//
// Ports
//   clk, reset            : system clock, synchronous active-high reset
//   pixel_x/y, visible,
//   p_tick, hsync/vsync_in: raster inputs from the sync generator
//   cell_x/y, cell_kind   : combinational board query / answer
//   score                 : BCD score, most significant digit in top nibble
//   game_over             : dims the board while high
//   clear_start/rows      : request a row flash with a row mask
//   busy, clear_done      : flash in progress / one-cycle end pulse
//   tile_addr/data        : tile+digit ROM, 1-cycle read latency
//   bg_addr/data          : background ROM, 1-cycle read latency
//   vga_*                 : display outputs, 3 clks after the pixel inputs
module tetris_renderer #(
    parameter int          COLS         = 10,
    parameter int          ROWS         = 20,
    parameter int          CELL_PX      = 20,
    parameter int          SCALE_SHIFT  = 1,
    parameter int          BOARD_X0     = 220,
    parameter int          BOARD_Y0     = 40,
    parameter int          KINDS        = 7,
    parameter int          DIGITS       = 4,
    parameter int          DIGIT_X0     = 128,
    parameter int          DIGIT_Y0     = 450,
    parameter int          DIGIT_PITCH  = 14,
    parameter int          NUM_W        = 5,
    parameter int          NUM_H        = 9,
    parameter int          BG_W         = 320,
    parameter int          ROM_AW       = 17,
    parameter int          FLASH_FRAMES = 24,
    parameter int          FLASH_HALF   = 4,
    parameter logic [11:0] FLASH_COLOR  = 12'hFF0,
    parameter logic [11:0] KEY_COLOR    = 12'hFFF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [9:0]                pixel_x,
    input  logic [9:0]                pixel_y,
    input  logic                      visible,
    input  logic                      p_tick,
    input  logic                      hsync_in,
    input  logic                      vsync_in,
    output logic [$clog2(COLS)-1:0]   cell_x,
    output logic [$clog2(ROWS)-1:0]   cell_y,
    input  logic [3:0]                cell_kind,
    input  logic [4*DIGITS-1:0]       score,
    input  logic                      game_over,
    input  logic                      clear_start,
    input  logic [ROWS-1:0]           clear_rows,
    output logic                      busy,
    output logic                      clear_done,
    output logic [ROM_AW-1:0]         tile_addr,
    input  logic [11:0]               tile_data,
    output logic [16:0]               bg_addr,
    input  logic [11:0]               bg_data,
    output logic                      vga_hsync,
    output logic                      vga_vsync,
    output logic [11:0]               vga_rgb
);

    localparam int TILE       = CELL_PX >> SCALE_SHIFT;
    localparam int KIND_AREA  = TILE * TILE;
    localparam int DIGIT_BASE = KINDS * KIND_AREA;
    localparam int DIGIT_AREA = NUM_W * NUM_H;
    localparam int KEY_ADDR   = DIGIT_BASE + 10 * DIGIT_AREA;
    localparam int BOARD_W    = COLS * CELL_PX;
    localparam int BOARD_H    = ROWS * CELL_PX;
    localparam int DBOX_W     = NUM_W << SCALE_SHIFT;
    localparam int DBOX_H     = NUM_H << SCALE_SHIFT;
    localparam int CXW        = $clog2(COLS);
    localparam int CYW        = $clog2(ROWS);
    localparam int FCW        = $clog2(FLASH_FRAMES);

    typedef enum logic {S_IDLE, S_FLASH} state_t;

    state_t           r_state;
    logic [FCW-1:0]   r_fc;
    logic [ROWS-1:0]  r_mask;
    logic             r_busy;
    logic             r_clear_done;

    logic [ROM_AW-1:0] r_tile_addr;
    logic [16:0]       r_bg_addr;
    logic r_vis1, r_pt1, r_hs1, r_vs1, r_inb1, r_fh1;
    logic r_vis2, r_pt2, r_hs2, r_vs2, r_inb2, r_fh2;
    logic [11:0] r_rgb;
    logic        r_hsync, r_vsync;

    int          w_dx, w_dy, w_cx, w_cy, w_tcol, w_trow;
    int          w_dox, w_doy, w_dig_addr, w_tile, w_bg;
    logic        w_in_board, w_lead_zero, w_show, w_dig_hit;
    logic [3:0]  w_nib;
    logic        w_frame_tick, w_phase_on, w_flash_hit;
    logic [11:0] w_pix;

    // Board geometry, digit lookup and next ROM addresses
    always_comb begin
        w_dx       = int'(pixel_x) - BOARD_X0;
        w_dy       = int'(pixel_y) - BOARD_Y0;
        w_in_board = (w_dx >= 0) && (w_dx < BOARD_W) && (w_dy >= 0) && (w_dy < BOARD_H);
        w_cx       = w_in_board ? w_dx / CELL_PX : 0;
        w_cy       = w_in_board ? w_dy / CELL_PX : 0;
        w_tcol     = (w_dx % CELL_PX) >> SCALE_SHIFT;
        w_trow     = (w_dy % CELL_PX) >> SCALE_SHIFT;

        // Leading zeros are blanked, scanning from the most significant digit;
        // the last digit always shows so a zero score reads "0".
        w_lead_zero = 1'b1;
        w_show      = 1'b0;
        w_dig_hit   = 1'b0;
        w_dig_addr  = KEY_ADDR;
        w_nib       = 4'd0;
        w_dox       = 0;
        w_doy       = 0;
        for (int i = 0; i < DIGITS; i++) begin
            w_nib       = score[4*(DIGITS-1-i) +: 4];
            w_lead_zero = w_lead_zero && (w_nib == 4'd0);
            w_show      = (w_nib <= 4'd9) && !((i < DIGITS-1) && w_lead_zero);
            w_dox       = int'(pixel_x) - (DIGIT_X0 + i * DIGIT_PITCH);
            w_doy       = int'(pixel_y) - DIGIT_Y0;
            if (!w_dig_hit && w_dox >= 0 && w_dox < DBOX_W && w_doy >= 0 && w_doy < DBOX_H) begin
                w_dig_hit = 1'b1;
                if (w_show)
                    w_dig_addr = DIGIT_BASE + int'(w_nib) * DIGIT_AREA
                                 + (w_doy >> SCALE_SHIFT) * NUM_W + (w_dox >> SCALE_SHIFT);
            end
        end

        if (w_in_board) begin
            if (cell_kind != 4'd0 && int'(cell_kind) <= KINDS)
                w_tile = (int'(cell_kind) - 1) * KIND_AREA + w_trow * TILE + w_tcol;
            else
                w_tile = KEY_ADDR;
        end else begin
            w_tile = w_dig_addr;
        end

        w_bg = (int'(pixel_y) >> SCALE_SHIFT) * BG_W + (int'(pixel_x) >> SCALE_SHIFT);

        w_frame_tick = p_tick && (pixel_x == 10'd0) && (pixel_y == 10'd0);
        w_phase_on   = ((int'(r_fc) / FLASH_HALF) % 2) == 0;
        w_flash_hit  = (r_state == S_FLASH) && w_phase_on && w_in_board && r_mask[cell_y];
    end

    assign cell_x = CXW'(w_cx);
    assign cell_y = CYW'(w_cy);

    // Stage 3 colour: flash overrides tiles, key-coloured tiles show background
    always_comb begin
        if (!r_vis2)
            w_pix = 12'h000;
        else if (r_fh2)
            w_pix = FLASH_COLOR;
        else if (tile_data != KEY_COLOR)
            w_pix = tile_data;
        else
            w_pix = bg_data;
        if (game_over && r_inb2)
            w_pix = (w_pix >> 1) & 12'h777;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tile_addr <= ROM_AW'(KEY_ADDR);
            r_bg_addr   <= '0;
            {r_vis1, r_pt1, r_hs1, r_vs1, r_inb1, r_fh1} <= '0;
            {r_vis2, r_pt2, r_hs2, r_vs2, r_inb2, r_fh2} <= '0;
            r_rgb       <= '0;
            r_hsync     <= 1'b0;
            r_vsync     <= 1'b0;
        end else begin
            r_tile_addr <= ROM_AW'(w_tile);
            r_bg_addr   <= 17'(w_bg);
            {r_vis1, r_pt1, r_hs1, r_vs1, r_inb1, r_fh1} <=
                {visible, p_tick, hsync_in, vsync_in, w_in_board, w_flash_hit};
            {r_vis2, r_pt2, r_hs2, r_vs2, r_inb2, r_fh2} <=
                {r_vis1, r_pt1, r_hs1, r_vs1, r_inb1, r_fh1};
            if (r_pt2)
                r_rgb <= w_pix;
            r_hsync <= r_hs2;
            r_vsync <= r_vs2;
        end
    end

    // Flash FSM; the frame_tick that coincides with clear_start is not counted
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_fc         <= '0;
            r_mask       <= '0;
            r_busy       <= 1'b0;
            r_clear_done <= 1'b0;
        end else begin
            r_clear_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (clear_start) begin
                        r_mask  <= clear_rows;
                        r_fc    <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_FLASH;
                    end
                end
                S_FLASH: begin
                    if (w_frame_tick) begin
                        if (r_fc == FCW'(FLASH_FRAMES - 1)) begin
                            r_state      <= S_IDLE;
                            r_busy       <= 1'b0;
                            r_clear_done <= 1'b1;
                        end else begin
                            r_fc <= r_fc + FCW'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy       = r_busy;
    assign clear_done = r_clear_done;
    assign tile_addr  = r_tile_addr;
    assign bg_addr    = r_bg_addr;
    assign vga_rgb    = r_rgb;
    assign vga_hsync  = r_hsync;
    assign vga_vsync  = r_vsync;

endmodule

// File: tb/tb_tetris_renderer.sv
// Directed bench for tetris_renderer with default parameters. Tile and
// background ROMs are modelled as 1-cycle registered reads.
module tb_tetris_renderer;

    localparam int KEY = 1150;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  pixel_x, pixel_y;
    logic        visible, p_tick, hsync_in, vsync_in;
    logic [3:0]  cell_x;
    logic [4:0]  cell_y;
    logic [3:0]  cell_kind;
    logic [15:0] score;
    logic        game_over, clear_start;
    logic [19:0] clear_rows;
    logic        busy, clear_done;
    logic [16:0] tile_addr;
    logic [11:0] tile_data;
    logic [16:0] bg_addr;
    logic [11:0] bg_data;
    logic        vga_hsync, vga_vsync;
    logic [11:0] vga_rgb;
    logic [11:0] tile_val;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tetris_renderer dut (
        .clk(clk), .reset(reset),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .visible(visible), .p_tick(p_tick),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .cell_x(cell_x), .cell_y(cell_y), .cell_kind(cell_kind),
        .score(score), .game_over(game_over),
        .clear_start(clear_start), .clear_rows(clear_rows),
        .busy(busy), .clear_done(clear_done),
        .tile_addr(tile_addr), .tile_data(tile_data),
        .bg_addr(bg_addr), .bg_data(bg_data),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_rgb(vga_rgb)
    );

    always @(posedge clk) begin
        tile_data <= (tile_addr == 17'd1150) ? 12'hFFF : tile_val;
        bg_data   <= bg_addr[11:0] ^ {7'd0, bg_addr[16:12]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] exp_bg(input int x, input int y);
        logic [16:0] a;
        a = 17'(((y >> 1) * 320) + (x >> 1));
        return a[11:0] ^ {7'd0, a[16:12]};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input int x, input int y);
        pixel_x = 10'(x);
        pixel_y = 10'(y);
    endtask

    task automatic render(input int x, input int y, input logic [3:0] k,
                          input logic vis, output logic [11:0] rgb);
        set_pix(x, y);
        cell_kind = k;
        visible   = vis;
        p_tick    = 1'b1;
        step;
        p_tick = 1'b0;
        step;
        step;
        rgb = vga_rgb;
    endtask

    task automatic frame_tick;
        set_pix(0, 0);
        p_tick = 1'b1;
        step;
        p_tick = 1'b0;
    endtask

    // board address vectors: x, y, kind, cell_x, cell_y, tile_addr
    int bv [7][6] = '{
        '{220, 40,  3, 0, 0, 200},
        '{239, 59,  3, 0, 0, 299},
        '{245, 65,  7, 1, 1, 622},
        '{419, 439, 1, 9, 19, 99},
        '{420, 40,  1, 0, 0, KEY},
        '{220, 40,  0, 0, 0, KEY},
        '{220, 40,  8, 0, 0, KEY}
    };

    // digit vectors: score, x, y, tile_addr
    int dv [13][4] = '{
        '{32'h0042, 156, 450, 880},
        '{32'h0042, 171, 452, 795},
        '{32'h0042, 128, 450, KEY},
        '{32'h0042, 142, 450, KEY},
        '{32'h0042, 165, 467, 924},
        '{32'h0042, 166, 450, KEY},
        '{32'h0000, 170, 450, 700},
        '{32'h0000, 156, 450, KEY},
        '{32'h1A23, 128, 450, 745},
        '{32'h1A23, 142, 450, KEY},
        '{32'h1A23, 157, 451, 790},
        '{32'h1020, 142, 450, 700},
        '{32'h00F5, 156, 450, KEY}
    };

    initial begin
        logic [11:0] rgb;
        logic [11:0] exp;
        int          done_seen;

        reset = 1'b1; set_pix(0, 0); visible = 0; p_tick = 0;
        hsync_in = 0; vsync_in = 0; cell_kind = 0; score = 16'h0000;
        game_over = 0; clear_start = 0; clear_rows = '0; tile_val = 12'h123;
        step; step;
        check("rst_tile_addr", 32'(tile_addr), KEY);
        check("rst_bg_addr", 32'(bg_addr), 0);
        check("rst_rgb", 32'(vga_rgb), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(clear_done), 0);
        check("rst_syncs", 32'({vga_hsync, vga_vsync}), 0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            set_pix(bv[i][0], bv[i][1]);
            cell_kind = 4'(bv[i][2]);
            #1;
            check("cell_x", 32'(cell_x), 32'(bv[i][3]));
            check("cell_y", 32'(cell_y), 32'(bv[i][4]));
            step;
            check("board_tile_addr", 32'(tile_addr), 32'(bv[i][5]));
        end
        set_pix(239, 59);
        step;
        check("bg_addr", 32'(bg_addr), 9399);

        cell_kind = 4'd1;
        for (int i = 0; i < 13; i++) begin
            score = 16'(dv[i][0]);
            set_pix(dv[i][1], dv[i][2]);
            step;
            check("digit_tile_addr", 32'(tile_addr), 32'(dv[i][3]));
        end

        // pipeline latency and hold
        score = 16'h0000; cell_kind = 0; visible = 1'b1;
        set_pix(10, 10); hsync_in = 1'b1; p_tick = 1'b1;
        step;
        p_tick = 1'b0; hsync_in = 1'b0; set_pix(30, 30);
        check("lat_clk1_rgb", 32'(vga_rgb), 0);
        step;
        check("lat_clk2_rgb", 32'(vga_rgb), 0);
        check("lat_clk2_hs", 32'(vga_hsync), 0);
        step;
        check("lat_clk3_rgb", 32'(vga_rgb), 32'(exp_bg(10, 10)));
        check("lat_clk3_hs", 32'(vga_hsync), 1);
        step;
        check("hold_rgb", 32'(vga_rgb), 32'(exp_bg(10, 10)));
        check("hs_follow", 32'(vga_hsync), 0);

        // composition and game-over dimming
        tile_val = 12'hF84; game_over = 1'b1;
        render(220, 40, 3, 1, rgb); check("dim_board", 32'(rgb), 32'h742);
        render(10, 10, 0, 1, rgb);  check("dim_outside", 32'(rgb), 32'(exp_bg(10, 10)));
        game_over = 1'b0;
        render(220, 40, 3, 1, rgb); check("tile_rgb", 32'(rgb), 32'hF84);
        render(220, 40, 0, 1, rgb); check("key_to_bg", 32'(rgb), 32'(exp_bg(220, 40)));
        render(220, 40, 3, 0, rgb); check("invisible", 32'(rgb), 0);

        // row 5 flash; a second request at frame 2 must be ignored
        clear_rows = 20'h00020; clear_start = 1'b1;
        step;
        clear_start = 1'b0;
        check("flash_busy", 32'(busy), 1);
        for (int f = 0; f < 24; f++) begin
            render(220, 140, 0, 1, rgb);
            exp = (((f / 4) % 2) == 0) ? 12'hFF0 : exp_bg(220, 140);
            check("flash_row5", 32'(rgb), 32'(exp));
            if (f == 0 || f == 8) begin
                render(220, 160, 0, 1, rgb);
                check("flash_row6", 32'(rgb), 32'(exp_bg(220, 160)));
            end
            if (f == 2) begin
                clear_rows = 20'h00040; clear_start = 1'b1;
                step;
                clear_start = 1'b0;
            end
            frame_tick;
            check("flash_done", 32'(clear_done), 32'(f == 23));
            check("flash_busy_tick", 32'(busy), 32'(f != 23));
        end
        step;
        check("done_one_cycle", 32'(clear_done), 0);
        render(220, 140, 0, 1, rgb);
        check("after_flash", 32'(rgb), 32'(exp_bg(220, 140)));

        // reset mid-flash aborts without a done pulse
        clear_rows = 20'h00020; clear_start = 1'b1;
        step;
        clear_start = 1'b0;
        frame_tick; frame_tick; frame_tick;
        reset = 1'b1;
        step;
        reset = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_tile_addr", 32'(tile_addr), KEY);
        check("abort_rgb", 32'(vga_rgb), 0);
        done_seen = 0;
        for (int f = 0; f < 24; f++) begin
            frame_tick;
            if (clear_done) done_seen++;
        end
        check("abort_no_done", 32'(done_seen), 0);
        render(220, 140, 0, 1, rgb);
        check("abort_mask_clr", 32'(rgb), 32'(exp_bg(220, 140)));

        // start coincident with frame_tick, empty mask: full 24-frame run
        clear_rows = '0;
        set_pix(0, 0); p_tick = 1'b1; clear_start = 1'b1;
        step;
        p_tick = 1'b0; clear_start = 1'b0;
        check("coinc_busy", 32'(busy), 1);
        render(220, 140, 0, 1, rgb);
        check("empty_mask", 32'(rgb), 32'(exp_bg(220, 140)));
        done_seen = 0;
        for (int f = 0; f < 23; f++) begin
            frame_tick;
            if (clear_done) done_seen++;
        end
        check("coinc_no_early", 32'(done_seen), 0);
        check("coinc_busy23", 32'(busy), 1);
        frame_tick;
        check("coinc_done", 32'(clear_done), 1);
        check("coinc_idle", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
